// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding plus line-level and parity constants shared by the UART TX and RX paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/tx_serializer.sv
// tx_serializer: word shift register and bit counter feeding the transmitter LSB first
module tx_serializer #(
  parameter int DATA_width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_width-1:0] data,
  output logic                  cur_bit,
  output logic                  nxt_bit,
  output logic                  last
);
  localparam int CW = (DATA_width > 1) ? $clog2(DATA_width) : 1;
  logic [DATA_width-1:0] sreg;
  logic [CW-1:0]         bit_cnt;
  // capture a new word, or retire the bit on the line and step bit_cnt (wrapping after the final bit)
  always_ff @(posedge clk)
    if (!reset_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= data;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= sreg >> 1;
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
    end
  assign cur_bit = sreg[0];
  assign nxt_bit = sreg[1];
  assign last    = bit_cnt == CW'(DATA_width - 1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: framed UART transmitter (start, data LSB first, optional parity under UART_TX_PARITY_EN, stop)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_width     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_width-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic [Prescale_width-1:0] Prescale,
`ifdef UART_TX_PARITY_EN
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
`endif
  output logic                      TX_OUT,
  output logic                      busy
);
  state_t                    state, state_nxt;
  logic [Prescale_width-1:0] presc_q, edge_cnt, edge_last;
  logic                      tx_q, tx_nxt, accept, tick, shift, cur_bit, nxt_bit, last, par_go, par_bit;
  assign accept    = (state == IDLE) && Data_Valid;
  assign edge_last = (presc_q > Prescale_width'(1)) ? presc_q - Prescale_width'(1) : '0;
  assign tick      = edge_cnt == edge_last;
  assign TX_OUT    = tx_q;
  assign busy      = state inside {START, DATA, PARITY, STOP};
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit_q;
  // latch the frame's parity choice and precomputed parity bit with the word
  always_ff @(posedge clk)
    if (!reset_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= PAR_EN;
      par_bit_q <= ^P_DATA ^ (PAR_TYP == PAR_ODD);
    end
  assign par_go  = par_en_q;
  assign par_bit = par_bit_q;
`else
  assign par_go  = 1'b0;
  assign par_bit = 1'b0;
`endif
  tx_serializer #(.DATA_width(DATA_width)) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .shift   (shift),
    .data    (P_DATA),
    .cur_bit (cur_bit),
    .nxt_bit (nxt_bit),
    .last    (last)
  );
  // next state and next line level; the line level is registered so TX_OUT changes on the bit edge itself
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_q;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = Data_Valid ? START : IDLE;
        tx_nxt    = Data_Valid ? START_BIT : STOP_BIT;
      end
      START: if (tick) begin
        state_nxt = DATA;
        tx_nxt    = cur_bit;
      end
      DATA: if (tick) begin
        shift     = 1'b1;
        state_nxt = !last ? DATA : par_go ? PARITY : STOP;
        tx_nxt    = !last ? nxt_bit : par_go ? par_bit : STOP_BIT;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_nxt = STOP;
        tx_nxt    = STOP_BIT;
      end
`endif
      STOP: if (tick) begin
        state_nxt = IDLE;
        tx_nxt    = STOP_BIT;
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = STOP_BIT;
      end
    endcase
  end
  // state, line register, per-bit edge counter and the prescale latched for the whole frame
  always_ff @(posedge clk)
    if (!reset_n) begin
      state    <= IDLE;
      tx_q     <= STOP_BIT;
      edge_cnt <= '0;
      presc_q  <= '0;
    end else begin
      state    <= state_nxt;
      tx_q     <= tx_nxt;
      edge_cnt <= (state == IDLE || tick) ? '0 : edge_cnt + 1'b1;
      if (accept) presc_q <= Prescale;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frame-level checking of uart_tx against a bench-side line model
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic [5:0] Prescale = 6'd8;
`ifdef UART_TX_PARITY_EN
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
`endif
  logic       TX_OUT, busy;
  int         checks = 0, errors = 0;
  bit         chk_en = 1'b0;
  logic       cap [0:4095];
  int         cap_n;

  uart_tx #(.DATA_width(8), .Prescale_width(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Prescale   (Prescale),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
`endif
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // line model: a frame is a list of bit values, each held for len cycles from the accepting edge
  bit   m_act = 1'b0;
  int   m_t = 0, m_len = 1, m_nb = 10;
  logic m_bits [0:10];
  logic exp_tx = 1'b1, exp_busy = 1'b0;
  always @(posedge clk) begin
    if (!reset_n) m_act = 1'b0;
    else if (m_act) begin
      m_t++;
      if (m_t == m_nb * m_len) m_act = 1'b0;
    end else if (Data_Valid) begin
      m_act = 1'b1;
      m_t = 0;
      m_len = (Prescale < 2) ? 1 : int'(Prescale);
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[1 + i] = P_DATA[i];
      m_nb = 10;
`ifdef UART_TX_PARITY_EN
      if (PAR_EN) begin
        m_bits[9] = (^P_DATA) ^ PAR_TYP;
        m_nb = 11;
      end
`endif
      m_bits[m_nb - 1] = 1'b1;
    end
    exp_busy = m_act;
    exp_tx = m_act ? m_bits[m_t / m_len] : 1'b1;
  end

  always @(negedge clk)
    if (chk_en) begin
      checks++;
      if (TX_OUT !== exp_tx || busy !== exp_busy) begin
        errors++;
        $display("FAIL cycle @%0t TX_OUT=%b want %b busy=%b want %b", $time, TX_OUT, exp_tx, busy, exp_busy);
      end
    end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [5:0] p);
    @(negedge clk);
    P_DATA = d;
    Prescale = p;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  task automatic capture(input int inj_at, input logic [7:0] inj_d, input int pchg_at, input logic [5:0] pchg);
    cap_n = 0;
    while (busy === 1'b1 && cap_n < 4096) begin
      cap[cap_n] = TX_OUT;
      Data_Valid = (cap_n == inj_at);
      if (cap_n == inj_at) P_DATA = inj_d;
      if (cap_n == pchg_at) Prescale = pchg;
      cap_n++;
      @(negedge clk);
    end
    Data_Valid = 1'b0;
    if (cap_n >= 4096) begin
      checks++;
      errors++;
      $display("FAIL timeout busy still high after %0d cycles", cap_n);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [5:0] p);
    send(d, p);
    capture(-1, 8'h00, -1, 6'd0);
  endtask

  initial begin
    int n1, g, n2, len, par, inj;
    logic [7:0] d;
    logic [5:0] p;
    logic exp_a5 [0:9];
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_tx", int'(TX_OUT), 1);
    check("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(8'hA5, 6'd8);
    check("a5_busy_len", cap_n, 80);
    for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), int'(cap[4 + 8 * k]), int'(exp_a5[k]));

`ifdef UART_TX_PARITY_EN
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    frame(8'h07, 6'd8);
    check("par_even_len", cap_n, 88);
    check("par_even_bit", int'(cap[76]), 1);
    PAR_TYP = 1'b1;
    frame(8'h07, 6'd8);
    check("par_odd_len", cap_n, 88);
    check("par_odd_bit", int'(cap[76]), 0);
    PAR_EN = 1'b0;
`endif

    send(8'hFF, 6'd4);
    capture(10, 8'h3C, -1, 6'd0);
    check("drop_len", cap_n, 40);
    for (int k = 1; k < 9; k++) check($sformatf("drop_bit%0d", k), int'(cap[4 * k + 2]), 1);
    repeat (3) @(negedge clk);
    check("drop_no_refire", int'(busy), 0);

    @(negedge clk);
    P_DATA = 8'h96;
    Prescale = 6'd16;
    Data_Valid = 1'b1;
    @(negedge clk);
    P_DATA = 8'h41;
    n1 = 0;
    while (busy && n1 < 1000) begin n1++; @(negedge clk); end
    g = 0;
    while (!busy && g < 1000) begin g++; @(negedge clk); end
    Data_Valid = 1'b0;
    n2 = 0;
    while (busy && n2 < 1000) begin n2++; @(negedge clk); end
    check("b2b_len1", n1, 160);
    check("b2b_gap", g, 1);
    check("b2b_len2", n2, 160);

    send(8'h5B, 6'd4);
    repeat (17) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(TX_OUT), 1);
    check("abort_busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
    frame(8'hC3, 6'd5);
    check("after_abort_len", cap_n, 50);

    send(8'h5A, 6'd8);
    capture(-1, 8'h00, 20, 6'd32);
    check("pchg_cur_len", cap_n, 80);
    send(8'h5A, 6'd32);
    capture(-1, 8'h00, -1, 6'd0);
    check("pchg_next_len", cap_n, 320);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom);
      p = 6'($urandom_range(0, 9));
      par = 0;
`ifdef UART_TX_PARITY_EN
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      par = int'(PAR_EN);
`endif
      len = (10 + par) * ((p < 2) ? 1 : int'(p));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 2)) : -1;
      send(d, p);
      capture(inj, 8'($urandom), -1, 6'd0);
      check($sformatf("rand%0d_len", it), cap_n, len);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
